// File: rtl/jesd204_frame_mark_sequencer.sv
// JESD204 LMFC sequencer: SYSREF capture, multiframe counter, frame reset release.
// Optional JESD204_FRAME_SEQ_ERR_COUNT_EN builds the saturating SYSREF error counter.
module jesd204_frame_mark_sequencer #(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int LMFC_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sysref,
    input  logic [LMFC_CNT_W-1:0] cfg_beats_per_multiframe,
    input  logic [LMFC_CNT_W-1:0] cfg_lmfc_offset,
    input  logic                  cfg_sysref_oneshot,
    output logic [LMFC_CNT_W-1:0] lmfc_counter,
    output logic                  lmfc_edge,
    output logic                  frame_reset,
    output logic                  aligned,
    output logic [1:0]            status_state,
    output logic                  sysref_edge,
    output logic                  sysref_alignment_error,
    output logic [7:0]            status_sysref_err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SYNC = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    if (DATA_PATH_WIDTH < 1) begin : g_dpw_invalid
    end

    state_t                r_state;
    state_t                w_state_next;
    logic [LMFC_CNT_W-1:0] r_cnt;
    logic [LMFC_CNT_W-1:0] w_cnt_inc;
    logic [LMFC_CNT_W-1:0] w_cnt_next;
    logic [LMFC_CNT_W-1:0] w_load;
    logic                  r_sysref_q;
    logic                  r_sysref_d;
    logic                  w_sysref_edge;
    logic                  w_align_err;
    logic                  w_err_clr;
    logic                  r_lmfc_edge;
    logic                  r_frame_reset;
    logic                  r_sysref_edge;
    logic                  r_align_err;

    assign w_sysref_edge = r_sysref_q & ~r_sysref_d;
    assign w_cnt_inc     = (r_cnt == cfg_beats_per_multiframe) ? '0 : r_cnt + 1'b1;
    // An offset beyond the multiframe length would never be reached; fall back to 0
    assign w_load = (cfg_lmfc_offset > cfg_beats_per_multiframe) ? '0 : cfg_lmfc_offset;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_inc;
        w_align_err  = 1'b0;
        w_err_clr    = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_cnt_next   = '0;
                    w_state_next = ST_WAIT;
                    w_err_clr    = 1'b1;
                end
                ST_WAIT: begin
                    if (w_sysref_edge) begin
                        w_cnt_next   = w_load;
                        w_state_next = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_sysref_edge) begin
                        w_cnt_next = w_load;
                    end else if (w_cnt_inc == '0) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_sysref_edge && (w_cnt_inc != w_load)) begin
                        w_align_err = 1'b1;
                        if (!cfg_sysref_oneshot) begin
                            w_cnt_next   = w_load;
                            w_state_next = ST_SYNC;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_sysref_q    <= 1'b0;
            r_sysref_d    <= 1'b0;
            r_lmfc_edge   <= 1'b0;
            r_frame_reset <= 1'b1;
            r_sysref_edge <= 1'b0;
            r_align_err   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_sysref_q    <= sysref;
            r_sysref_d    <= r_sysref_q;
            r_lmfc_edge   <= (w_cnt_next == '0) &&
                             ((w_state_next == ST_SYNC) || (w_state_next == ST_RUN));
            r_frame_reset <= (w_state_next != ST_RUN);
            r_sysref_edge <= w_sysref_edge;
            r_align_err   <= w_align_err;
        end
    end

`ifdef JESD204_FRAME_SEQ_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err_clr) begin
            r_err_count <= '0;
        end else if (w_align_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign status_sysref_err_count = r_err_count;
`else
    assign status_sysref_err_count = '0;
`endif

    assign lmfc_counter           = r_cnt;
    assign lmfc_edge              = r_lmfc_edge;
    assign frame_reset            = r_frame_reset;
    assign aligned                = (r_state == ST_RUN);
    assign status_state           = r_state;
    assign sysref_edge            = r_sysref_edge;
    assign sysref_alignment_error = r_align_err;

endmodule

// File: tb/tb_jesd204_frame_mark_sequencer.sv
// Self-checking bench for jesd204_frame_mark_sequencer: cycle model plus directed literals.
module tb_jesd204_frame_mark_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable;
    logic       sysref;
    logic [7:0] cfg_beats;
    logic [7:0] cfg_off;
    logic       cfg_oneshot;
    logic [7:0] lmfc_counter;
    logic       lmfc_edge;
    logic       frame_reset;
    logic       aligned;
    logic [1:0] status_state;
    logic       sysref_edge;
    logic       sysref_alignment_error;
    logic [7:0] status_sysref_err_count;

    int checks = 0;
    int errors = 0;

    jesd204_frame_mark_sequencer #(
        .DATA_PATH_WIDTH(4),
        .LMFC_CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sysref(sysref),
        .cfg_beats_per_multiframe(cfg_beats),
        .cfg_lmfc_offset(cfg_off),
        .cfg_sysref_oneshot(cfg_oneshot),
        .lmfc_counter(lmfc_counter),
        .lmfc_edge(lmfc_edge),
        .frame_reset(frame_reset),
        .aligned(aligned),
        .status_state(status_state),
        .sysref_edge(sysref_edge),
        .sysref_alignment_error(sysref_alignment_error),
        .status_sysref_err_count(status_sysref_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
        bit q;
        bit d;
        bit fr;
        bit le;
        bit se;
        bit er;
        int ec;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.cnt = 0; r.q = 0; r.d = 0;
        r.fr = 1; r.le = 0; r.se = 0; r.er = 0; r.ec = 0;
        return r;
    endfunction

    // One link-clock step of the sequencer behaviour, in plain arithmetic
    function automatic mdl_t mdl_step(mdl_t c, bit en, bit sr, int beats, int off, bit os);
        mdl_t n;
        bit   e;
        int   len;
        int   ld;
        int   inc;
        n    = c;
        e    = c.q && !c.d;
        len  = beats + 1;
        ld   = (off > beats) ? 0 : off;
        inc  = (c.cnt + 1) % len;
        n.d  = c.q;
        n.q  = sr;
        n.cnt = inc;
        n.er = 0;
        if (!en) begin
            n.st = 0;
            n.cnt = 0;
        end else if (c.st == 0) begin
            n.st = 1;
            n.cnt = 0;
            n.ec = 0;
        end else if (e && (c.st == 1 || c.st == 2)) begin
            n.st = 2;
            n.cnt = ld;
        end else if (c.st == 2 && inc == 0) begin
            n.st = 3;
        end else if (c.st == 3 && e && inc != ld) begin
            n.er = 1;
            if (!os) begin
                n.st = 2;
                n.cnt = ld;
            end
        end
`ifdef JESD204_FRAME_SEQ_ERR_COUNT_EN
        if (n.er && n.ec < 255) n.ec = n.ec + 1;
`else
        n.ec = 0;
`endif
        n.fr = (n.st != 3);
        n.le = (n.cnt == 0) && (n.st >= 2);
        n.se = e;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mdl_reset();
        else m <= mdl_step(m, enable, sysref, int'(cfg_beats), int'(cfg_off), cfg_oneshot);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_cnt", int'(lmfc_counter), m.cnt);
            chk("model_state", int'(status_state), m.st);
            chk("model_aligned", int'(aligned), int'(m.st == 3));
            chk("model_lmfc_edge", int'(lmfc_edge), int'(m.le));
            chk("model_frame_reset", int'(frame_reset), int'(m.fr));
            chk("model_sysref_edge", int'(sysref_edge), int'(m.se));
            chk("model_align_err", int'(sysref_alignment_error), int'(m.er));
            chk("model_err_count", int'(status_sysref_err_count), m.ec);
        end
    end

    task automatic wait_cnt(input int x);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m.cnt == x) begin
                ok = 1;
                break;
            end
        end
        chk("wait_cnt_timeout", int'(ok), 1);
    endtask

    task automatic wait_state(input int s);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m.st == s) begin
                ok = 1;
                break;
            end
        end
        chk("wait_state_timeout", int'(ok), 1);
    endtask

    task automatic pulse();
        sysref = 1'b1;
        @(negedge clk);
        sysref = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(status_state), 0);
        chk({tag, "_cnt"}, int'(lmfc_counter), 0);
        chk({tag, "_lmfc_edge"}, int'(lmfc_edge), 0);
        chk({tag, "_frame_reset"}, int'(frame_reset), 1);
        chk({tag, "_aligned"}, int'(aligned), 0);
        chk({tag, "_sysref_edge"}, int'(sysref_edge), 0);
        chk({tag, "_align_err"}, int'(sysref_alignment_error), 0);
        chk({tag, "_err_count"}, int'(status_sysref_err_count), 0);
    endtask

    initial begin
        enable = 0;
        sysref = 0;
        cfg_beats = 8'd15;
        cfg_off = 8'd3;
        cfg_oneshot = 0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sysref = ~sysref;
        end
        sysref = 0;
        @(negedge clk);
        chk("idle_state", int'(status_state), 0);
        chk("idle_frame_reset", int'(frame_reset), 1);
        chk("idle_cnt", int'(lmfc_counter), 0);
        chk("idle_lmfc_edge", int'(lmfc_edge), 0);

        enable = 1;
        repeat (5) @(negedge clk);
        chk("wait_state", int'(status_state), 1);
        pulse();
        @(negedge clk);
        chk("load_cnt", int'(lmfc_counter), 3);
        chk("load_state", int'(status_state), 2);
        chk("load_sysref_edge", int'(sysref_edge), 1);
        chk("load_frame_reset", int'(frame_reset), 1);
        repeat (13) @(negedge clk);
        chk("wrap_cnt", int'(lmfc_counter), 0);
        chk("wrap_state", int'(status_state), 3);
        chk("wrap_frame_reset", int'(frame_reset), 0);
        chk("wrap_aligned", int'(aligned), 1);
        chk("wrap_lmfc_edge", int'(lmfc_edge), 1);
        repeat (16) @(negedge clk);
        chk("period_cnt", int'(lmfc_counter), 0);
        chk("period_lmfc_edge", int'(lmfc_edge), 1);

        for (int k = 0; k < 3; k++) begin
            repeat (20) @(negedge clk);
            wait_cnt(1);
            pulse();
            @(negedge clk);
            chk("inphase_err", int'(sysref_alignment_error), 0);
            chk("inphase_state", int'(status_state), 3);
            chk("inphase_cnt", int'(lmfc_counter), 3);
        end

        wait_cnt(2);
        pulse();
        @(negedge clk);
        chk("shift_err", int'(sysref_alignment_error), 1);
        chk("shift_state", int'(status_state), 2);
        chk("shift_frame_reset", int'(frame_reset), 1);
        chk("shift_cnt", int'(lmfc_counter), 3);
`ifdef JESD204_FRAME_SEQ_ERR_COUNT_EN
        chk("shift_err_count", int'(status_sysref_err_count), 1);
`else
        chk("shift_err_count", int'(status_sysref_err_count), 0);
`endif
        wait_state(3);
        chk("resync_frame_reset", int'(frame_reset), 0);

        enable = 0;
        repeat (2) @(negedge clk);
        cfg_oneshot = 1;
        enable = 1;
        repeat (3) @(negedge clk);
        pulse();
        wait_state(3);
        for (int k = 0; k < 300; k++) begin
            wait_cnt(2);
            pulse();
            if (k == 0) begin
                @(negedge clk);
                chk("oneshot_err", int'(sysref_alignment_error), 1);
                chk("oneshot_state", int'(status_state), 3);
                chk("oneshot_cnt", int'(lmfc_counter), 4);
            end
        end
        repeat (2) @(negedge clk);
`ifdef JESD204_FRAME_SEQ_ERR_COUNT_EN
        chk("sat_err_count", int'(status_sysref_err_count), 255);
`else
        chk("sat_err_count", int'(status_sysref_err_count), 0);
`endif
        chk("sat_state", int'(status_state), 3);

        wait_cnt(5);
        sysref = 1;
        @(negedge clk);
        enable = 0;
        sysref = 0;
        @(negedge clk);
        chk("drop_state", int'(status_state), 0);
        chk("drop_cnt", int'(lmfc_counter), 0);
        chk("drop_frame_reset", int'(frame_reset), 1);

        cfg_off = 8'd20;
        cfg_oneshot = 0;
        @(negedge clk);
        enable = 1;
        repeat (3) @(negedge clk);
        pulse();
        @(negedge clk);
        chk("off20_cnt", int'(lmfc_counter), 0);
        chk("off20_state", int'(status_state), 2);
        chk("off20_lmfc_edge", int'(lmfc_edge), 1);
        chk("off20_err_count", int'(status_sysref_err_count), 0);
        wait_state(3);
        chk("off20_run_cnt", int'(lmfc_counter), 0);

        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        #10;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
